// File: rtl/umi_req_arbiter.sv
// Round-robin arbiter sharing one UMI device request port among N hosts.
// Responses are steered back in order through a FIFO of requester indices.
module umi_req_arbiter #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int CW    = 32,
   parameter int AW    = 64,
   parameter int DW    = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0]              host_req_valid,
   input  logic [N*CW-1:0]           host_req_cmd,
   input  logic [N*AW-1:0]           host_req_dstaddr,
   input  logic [N*AW-1:0]           host_req_srcaddr,
   input  logic [N*DW-1:0]           host_req_data,
   output logic [N-1:0]              host_req_ready,
   output logic [N-1:0]              host_resp_valid,
   output logic [CW-1:0]             host_resp_cmd,
   output logic [AW-1:0]             host_resp_dstaddr,
   output logic [AW-1:0]             host_resp_srcaddr,
   output logic [DW-1:0]             host_resp_data,
   input  logic [N-1:0]              host_resp_ready,
   output logic                      dev_req_valid,
   output logic [CW-1:0]             dev_req_cmd,
   output logic [AW-1:0]             dev_req_dstaddr,
   output logic [AW-1:0]             dev_req_srcaddr,
   output logic [DW-1:0]             dev_req_data,
   input  logic                      dev_req_ready,
   input  logic                      dev_resp_valid,
   input  logic [CW-1:0]             dev_resp_cmd,
   input  logic [AW-1:0]             dev_resp_dstaddr,
   input  logic [AW-1:0]             dev_resp_srcaddr,
   input  logic [DW-1:0]             dev_resp_data,
   output logic                      dev_resp_ready,
   output logic [$clog2(DEPTH):0]    outstanding,
   output logic                      resp_orphan
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH) + 1;
   localparam logic [4:0] UMI_REQ_READ  = 5'h01;
   localparam logic [4:0] UMI_REQ_WRITE = 5'h03;
   localparam int EOM_BIT = 22;

   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic          locked;
   logic [PW-1:0] grant;
   logic          grant_valid;
   logic          eom;
   logic          non_posted;
   logic          full;
   logic          empty;
   logic          stall;
   logic          accept;
   logic          push;
   logic          pop;
   logic          orphan;

   logic [PW-1:0] fifo_mem [DEPTH];
   logic [FW-1:0] rd_ptr;
   logic [FW-1:0] wr_ptr;
   logic [OW-1:0] count;
   logic [PW-1:0] head;

   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N) s = s - N;
      return PW'(s);
   endfunction

   // Descending search so the lowest offset from ptr is written last and wins.
   always_comb begin
      grant       = owner;
      grant_valid = 1'b0;
      if (locked) begin
         grant_valid = host_req_valid[owner];
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (host_req_valid[rr_idx(ptr, k)]) begin
               grant       = rr_idx(ptr, k);
               grant_valid = 1'b1;
            end
         end
      end
   end

   assign dev_req_valid   = grant_valid;
   assign dev_req_cmd     = host_req_cmd[int'(grant)*CW +: CW];
   assign dev_req_dstaddr = host_req_dstaddr[int'(grant)*AW +: AW];
   assign dev_req_srcaddr = host_req_srcaddr[int'(grant)*AW +: AW];
   assign dev_req_data    = host_req_data[int'(grant)*DW +: DW];

   assign eom        = dev_req_cmd[EOM_BIT];
   assign non_posted = (dev_req_cmd[4:0] == UMI_REQ_READ) ||
                       (dev_req_cmd[4:0] == UMI_REQ_WRITE);
   assign full       = (count == OW'(DEPTH));
   assign empty      = (count == '0);
   // Full is judged on registered occupancy, so a same-cycle pop does not free a slot.
   assign stall      = full & non_posted;
   assign accept     = grant_valid & dev_req_ready & ~stall;
   assign push       = accept & non_posted;

   always_comb begin
      host_req_ready = '0;
      if (grant_valid) host_req_ready[grant] = dev_req_ready & ~stall;
   end

   assign head = fifo_mem[rd_ptr];

   always_comb begin
      host_resp_valid = '0;
      dev_resp_ready  = 1'b1;
      if (!empty) begin
         host_resp_valid[head] = dev_resp_valid;
         dev_resp_ready        = host_resp_ready[head];
      end
   end

   assign pop    = dev_resp_valid & dev_resp_ready & ~empty;
   assign orphan = dev_resp_valid & empty;

   assign host_resp_cmd     = dev_resp_cmd;
   assign host_resp_dstaddr = dev_resp_dstaddr;
   assign host_resp_srcaddr = dev_resp_srcaddr;
   assign host_resp_data    = dev_resp_data;
   assign outstanding       = count;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr         <= '0;
         owner       <= '0;
         locked      <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         resp_orphan <= 1'b0;
      end else begin
         if (accept) begin
            if (eom) begin
               locked <= 1'b0;
               ptr    <= rr_idx(grant, 1);
            end else begin
               locked <= 1'b1;
               owner  <= grant;
            end
         end
         if (push) wr_ptr <= wr_ptr + FW'(1);
         if (pop)  rd_ptr <= rd_ptr + FW'(1);
         case ({push, pop})
            2'b10:   count <= count + OW'(1);
            2'b01:   count <= count - OW'(1);
            default: count <= count;
         endcase
         if (orphan) resp_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Directed bench for umi_req_arbiter: grant order, locking, FIFO stall,
// in-order response steering, orphan detection and reset mid-transaction.
module tb_umi_req_arbiter;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 32;
   localparam int AW    = 64;
   localparam int DW    = 32;
   localparam int OW    = $clog2(DEPTH) + 1;
   localparam logic [4:0] OP_READ   = 5'h01;
   localparam logic [4:0] OP_POSTED = 5'h05;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    host_req_valid;
   logic [N*CW-1:0] host_req_cmd;
   logic [N*AW-1:0] host_req_dstaddr;
   logic [N*AW-1:0] host_req_srcaddr;
   logic [N*DW-1:0] host_req_data;
   logic [N-1:0]    host_req_ready;
   logic [N-1:0]    host_resp_valid;
   logic [CW-1:0]   host_resp_cmd;
   logic [AW-1:0]   host_resp_dstaddr;
   logic [AW-1:0]   host_resp_srcaddr;
   logic [DW-1:0]   host_resp_data;
   logic [N-1:0]    host_resp_ready;
   logic            dev_req_valid;
   logic [CW-1:0]   dev_req_cmd;
   logic [AW-1:0]   dev_req_dstaddr;
   logic [AW-1:0]   dev_req_srcaddr;
   logic [DW-1:0]   dev_req_data;
   logic            dev_req_ready;
   logic            dev_resp_valid;
   logic [CW-1:0]   dev_resp_cmd;
   logic [AW-1:0]   dev_resp_dstaddr;
   logic [AW-1:0]   dev_resp_srcaddr;
   logic [DW-1:0]   dev_resp_data;
   logic            dev_resp_ready;
   logic [OW-1:0]   outstanding;
   logic            resp_orphan;

   umi_req_arbiter #(.N(N), .DEPTH(DEPTH), .CW(CW), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .host_req_valid(host_req_valid), .host_req_cmd(host_req_cmd),
      .host_req_dstaddr(host_req_dstaddr), .host_req_srcaddr(host_req_srcaddr),
      .host_req_data(host_req_data), .host_req_ready(host_req_ready),
      .host_resp_valid(host_resp_valid), .host_resp_cmd(host_resp_cmd),
      .host_resp_dstaddr(host_resp_dstaddr), .host_resp_srcaddr(host_resp_srcaddr),
      .host_resp_data(host_resp_data), .host_resp_ready(host_resp_ready),
      .dev_req_valid(dev_req_valid), .dev_req_cmd(dev_req_cmd),
      .dev_req_dstaddr(dev_req_dstaddr), .dev_req_srcaddr(dev_req_srcaddr),
      .dev_req_data(dev_req_data), .dev_req_ready(dev_req_ready),
      .dev_resp_valid(dev_resp_valid), .dev_resp_cmd(dev_resp_cmd),
      .dev_resp_dstaddr(dev_resp_dstaddr), .dev_resp_srcaddr(dev_resp_srcaddr),
      .dev_resp_data(dev_resp_data), .dev_resp_ready(dev_resp_ready),
      .outstanding(outstanding), .resp_orphan(resp_orphan)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int exp_req[$];
   logic [N-1:0] exp_resp[$];

   function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic eom);
      logic [CW-1:0] c;
      c       = '0;
      c[4:0]  = op;
      c[22]   = eom;
      return c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] op, input logic eom);
      host_req_valid[i]          = v;
      host_req_cmd[i*CW +: CW]   = mk_cmd(op, eom);
   endtask

   task automatic monitor();
      int g;
      int e;
      logic [N-1:0] er;
      forever begin
         @(negedge clk);
         if (!reset && dev_req_valid && dev_req_ready && (host_req_ready != '0)) begin
            g = -1;
            for (int i = 0; i < N; i++) if (host_req_ready[i]) g = i;
            if (exp_req.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL req_unexpected: grant %0d accepted, none expected", g);
            end else begin
               e = exp_req.pop_front();
               check("req_grant", 64'(g), 64'(e));
               check("req_dstaddr", dev_req_dstaddr, 64'h1000 + 64'(e));
            end
         end
         if (!reset && dev_resp_valid && dev_resp_ready && (host_resp_valid != '0)) begin
            if (exp_resp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: host_resp_valid %b, none expected", host_resp_valid);
            end else begin
               er = exp_resp.pop_front();
               check("resp_route", 64'(host_resp_valid), 64'(er));
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      reset            = 1'b1;
      host_req_valid   = '0;
      host_req_cmd     = '0;
      host_req_srcaddr = '0;
      host_req_data    = '0;
      host_resp_ready  = '0;
      dev_req_ready    = 1'b0;
      dev_resp_valid   = 1'b0;
      dev_resp_cmd     = 32'h0000_000a;
      dev_resp_dstaddr = '0;
      dev_resp_srcaddr = '0;
      dev_resp_data    = 32'hdead_beef;
      for (int i = 0; i < N; i++) begin
         host_req_dstaddr[i*AW +: AW] = 64'h1000 + 64'(i);
         host_req_data[i*DW +: DW]    = DW'(i);
      end
      step(2);
      reset = 1'b0;
      #1;
      check("rst_outstanding", 64'(outstanding), 0);
      check("rst_orphan", 64'(resp_orphan), 0);
      check("rst_dev_req_valid", 64'(dev_req_valid), 0);
      check("rst_host_resp_valid", 64'(host_resp_valid), 0);
      check("rst_dev_resp_ready", 64'(dev_resp_ready), 1);

      // All four posted single-beat writers, continuous ready.
      for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_POSTED, 1'b1);
      dev_req_ready = 1'b1;
      for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) exp_req.push_back(i);
      #1;
      check("rr_first_ready", 64'(host_req_ready), 64'b0001);
      step(8);
      host_req_valid = '0;
      #1;
      check("rr_outstanding", 64'(outstanding), 0);

      // Move ptr to 2, then a 3-beat message from requester 2 amid contention.
      set_req(1, 1'b1, OP_POSTED, 1'b1);
      exp_req.push_back(1);
      step(1);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_POSTED, 1'b1);
      set_req(2, 1'b1, OP_POSTED, 1'b0);
      exp_req.push_back(2); exp_req.push_back(2); exp_req.push_back(2); exp_req.push_back(3);
      step(1);
      check("lock_hold_ready", 64'(host_req_ready), 64'b0100);
      step(1);
      set_req(2, 1'b1, OP_POSTED, 1'b1);
      step(1);
      check("after_eom_ready", 64'(host_req_ready), 64'b1000);
      step(1);
      host_req_valid = '0;

      // FIFO full stall with requester 1 reads.
      set_req(1, 1'b1, OP_READ, 1'b1);
      for (int i = 0; i < 4; i++) exp_req.push_back(1);
      step(4);
      check("full_outstanding", 64'(outstanding), 4);
      check("full_stall_ready", 64'(host_req_ready), 0);
      check("full_valid_held", 64'(dev_req_valid), 1);
      step(1);
      host_resp_ready = '1;
      dev_resp_valid  = 1'b1;
      exp_resp.push_back(4'b0010);
      #1;
      check("full_resp_valid", 64'(host_resp_valid), 64'b0010);
      check("full_pop_still_stall", 64'(host_req_ready), 0);
      step(1);
      dev_resp_valid = 1'b0;
      exp_req.push_back(1);
      #1;
      check("after_pop_ready", 64'(host_req_ready), 64'b0010);
      step(1);
      host_req_valid = '0;
      check("refill_outstanding", 64'(outstanding), 4);
      dev_resp_valid = 1'b1;
      for (int i = 0; i < 4; i++) exp_resp.push_back(4'b0010);
      step(4);
      dev_resp_valid = 1'b0;
      check("drain_outstanding", 64'(outstanding), 0);

      // Reads 0, 3, 1 then in-order responses with requester 3 back-pressuring.
      set_req(0, 1'b1, OP_READ, 1'b1); exp_req.push_back(0); step(1); host_req_valid = '0;
      set_req(3, 1'b1, OP_READ, 1'b1); exp_req.push_back(3); step(1); host_req_valid = '0;
      set_req(1, 1'b1, OP_READ, 1'b1); exp_req.push_back(1); step(1); host_req_valid = '0;
      check("order_outstanding", 64'(outstanding), 3);
      dev_resp_valid = 1'b1;
      exp_resp.push_back(4'b0001); exp_resp.push_back(4'b1000); exp_resp.push_back(4'b0010);
      step(1);
      host_resp_ready = 4'b0111;
      #1;
      check("bp_dev_resp_ready", 64'(dev_resp_ready), 0);
      check("bp_host_resp_valid", 64'(host_resp_valid), 64'b1000);
      step(1);
      check("bp_dev_resp_ready2", 64'(dev_resp_ready), 0);
      check("bp_outstanding", 64'(outstanding), 2);
      step(1);
      host_resp_ready = '1;
      step(2);
      dev_resp_valid = 1'b0;
      check("order_drained", 64'(outstanding), 0);

      // Orphan response with the FIFO empty.
      dev_resp_valid = 1'b1;
      #1;
      check("orphan_ready", 64'(dev_resp_ready), 1);
      check("orphan_no_valid", 64'(host_resp_valid), 0);
      check("orphan_not_yet", 64'(resp_orphan), 0);
      step(1);
      dev_resp_valid = 1'b0;
      check("orphan_set", 64'(resp_orphan), 1);
      step(3);
      check("orphan_held", 64'(resp_orphan), 1);

      // Reset while locked with three reads outstanding.
      set_req(0, 1'b1, OP_READ, 1'b0);
      for (int i = 0; i < 3; i++) exp_req.push_back(0);
      step(3);
      host_req_valid = '0;
      set_req(1, 1'b1, OP_POSTED, 1'b1);
      #1;
      check("locked_outstanding", 64'(outstanding), 3);
      check("locked_blocks_other", 64'(host_req_ready), 0);
      host_req_valid = '0;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      #1;
      check("rst2_outstanding", 64'(outstanding), 0);
      check("rst2_orphan", 64'(resp_orphan), 0);
      for (int i = 1; i < N; i++) set_req(i, 1'b1, OP_POSTED, 1'b1);
      exp_req.push_back(1);
      #1;
      check("rst2_grant_ready", 64'(host_req_ready), 64'b0010);
      step(1);
      host_req_valid = '0;
      dev_resp_valid = 1'b1;
      #1;
      check("inflight_no_valid", 64'(host_resp_valid), 0);
      step(1);
      dev_resp_valid = 1'b0;
      check("inflight_orphan", 64'(resp_orphan), 1);

      step(2);
      check("req_queue_empty", 64'(exp_req.size()), 0);
      check("resp_queue_empty", 64'(exp_resp.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
